// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and state codes for the interrupt pending latch
//
// Purpose: line count, index width and FSM state encoding used by
//          irq_pending_latch and the downstream priority encoder.
// Ports:   none (package).
package irq_pkg;

  localparam int N_LINES = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/req_edge_detect.sv
// rtl/req_edge_detect.sv - rising-edge detector for a vector of level inputs
//
// Purpose: registers the input vector every cycle and flags bits that went 0->1.
// Ports:
//   clk   - rising-edge clock
//   din   - level inputs
//   rise  - one-cycle pulse per bit on a 0->1 transition of din
module req_edge_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] r_din_q;

  // No reset on purpose: the history register keeps tracking the input
  // through reset, so a line held high across reset produces no edge.
  always_ff @(posedge clk) begin
    r_din_q <= din;
  end

  assign rise = din & ~r_din_q;

endmodule

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - edge-captured pending latch with masked priority presentation
//
// Purpose: latches rising edges of req into a pending register, tracks overruns,
//          and presents the lowest-index masked pending line as a held idx/valid
//          pair until acknowledged, followed by a one-cycle gap.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   req      - request lines (level; rising edges captured)
//   mask     - 1 = line enabled for presentation
//   ack      - consumer accepts the presented index (only while valid=1)
//   ovr_clr  - clears all overrun flags
//   pend_o   - registered pend & mask
//   valid    - idx holds a live request
//   idx      - presented line index, stable while valid=1
//   overrun  - sticky: edge arrived while that line was already pending
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] req,
  input  logic [N_LINES-1:0] mask,
  input  logic               ack,
  input  logic               ovr_clr,
  output logic [N_LINES-1:0] pend_o,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [N_LINES-1:0] overrun
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_sel;
  logic [N_LINES-1:0] r_pend;
  logic [N_LINES-1:0] r_pend_o;
  logic [N_LINES-1:0] r_overrun;
  logic [N_LINES-1:0] w_rise;
  logic [N_LINES-1:0] w_masked;
  logic [N_LINES-1:0] w_clr;
  logic [N_LINES-1:0] w_ovr_set;
  logic               w_ack_hit;

  // Lowest index wins, matching the downstream combinational encoder.
  function automatic logic [IDX_W-1:0] f_lowest(input logic [N_LINES-1:0] v);
    logic [IDX_W-1:0] sel;
    sel = '0;
    for (int n = N_LINES - 1; n >= 0; n--) begin
      if (v[n]) sel = IDX_W'(n);
    end
    return sel;
  endfunction

  req_edge_detect #(
    .WIDTH (N_LINES)
  ) u_edge (
    .clk  (clk),
    .din  (req),
    .rise (w_rise)
  );

  assign w_ack_hit = (r_state == S_REQ) && ack;
  assign w_clr     = w_ack_hit ? (N_LINES'(1) << r_idx) : '0;
  // A fresh edge on the line being acknowledged re-arms it rather than overrunning.
  assign w_ovr_set = w_rise & r_pend & ~w_clr;
  assign w_masked  = r_pend & mask;
  assign w_sel     = f_lowest(w_masked);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (|w_masked) begin
          w_state_nxt = S_REQ;
          w_idx_nxt   = w_sel;
        end
      end
      S_REQ: begin
        w_state_nxt = ack ? S_GAP : S_REQ;
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= '0;
      r_pend_o  <= '0;
      r_overrun <= '0;
    end else begin
      r_pend    <= (r_pend & ~w_clr) | w_rise;
      r_pend_o  <= w_masked;
      r_overrun <= (ovr_clr ? '0 : r_overrun) | w_ovr_set;
    end
  end

  assign pend_o  = r_pend_o;
  assign valid   = (r_state == S_REQ);
  assign idx     = r_idx;
  assign overrun = r_overrun;

endmodule
